sentinel_wb_mem: RTL and testbench

Wishbone classic responder: the memory/peripheral end of the Sentinel core's bus. Serves word-addressed RAM with byte-lane writes, inserts a fixed number of wait states, and optionally provides a memory-mapped machine timer driving the core's `irq` input. Used as a simulation/formal memory model and as the minimal on-chip RAM of small SoCs.

---
 rtl/sentinel_wb_pkg.sv | 38 +++
 rtl/sentinel_wb_timer.sv | 69 ++++++
 rtl/sentinel_wb_mem.sv | 172 +++++++++++++++++
 tb/tb_sentinel_wb_mem.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sentinel_wb_pkg.sv
// sentinel_wb_pkg: shared types and constants for the Sentinel Wishbone
// memory responder (FSM states, timer register map, wait-state range).
package sentinel_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } wb_state_e;

   // Timer block lives at byte address 0x4000_0000 (word 0x1000_0000).
   localparam logic [29:0] TIMER_BASE_WADR = 30'h1000_0000;

   localparam logic [1:0] TMR_MTIME_LO    = 2'd0;
   localparam logic [1:0] TMR_MTIME_HI    = 2'd1;
   localparam logic [1:0] TMR_MTIMECMP_LO = 2'd2;
   localparam logic [1:0] TMR_MTIMECMP_HI = 2'd3;

   localparam int WAIT_STATES_MIN = 0;
   localparam int WAIT_STATES_MAX = 2;

   // True when a word address falls inside the four timer registers.
   function automatic logic is_timer_adr(input logic [29:0] adr);
      return adr[29:2] == TIMER_BASE_WADR[29:2];
   endfunction

   // Replace only the byte lanes whose select bit is set.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/sentinel_wb_timer.sv
// sentinel_wb_timer: 64-bit machine timer (mtime / mtimecmp) with byte-lane
// writes and a registered irq = (mtime >= mtimecmp).
// The module only exists when SENTINEL_WB_MEM_TIMER_EN is defined, matching
// the only configuration in which sentinel_wb_mem instantiates it.
`ifdef SENTINEL_WB_MEM_TIMER_EN
module sentinel_wb_timer
   import sentinel_wb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [1:0]  wr_idx,
   input  logic [3:0]  wr_sel,
   input  logic [31:0] wr_data,
   input  logic [1:0]  rd_idx,
   output logic [31:0] rd_data,
   output logic        irq
);

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        irq_q, irq_d;

   // Next-state: free-running increment unless a bus write replaces it.
   always_comb begin
      mtime_d    = mtime_q + 64'd1;
      mtimecmp_d = mtimecmp_q;
      irq_d      = (mtime_q >= mtimecmp_q);
      if (wr_en) begin
         case (wr_idx)
            TMR_MTIME_LO:    mtime_d = {mtime_q[63:32],
                                        lane_merge(mtime_q[31:0], wr_data, wr_sel)};
            TMR_MTIME_HI:    mtime_d = {lane_merge(mtime_q[63:32], wr_data, wr_sel),
                                        mtime_q[31:0]};
            TMR_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32],
                                           lane_merge(mtimecmp_q[31:0], wr_data, wr_sel)};
            default:         mtimecmp_d = {lane_merge(mtimecmp_q[63:32], wr_data, wr_sel),
                                           mtimecmp_q[31:0]};
         endcase
      end
   end

   // Timer state registers; compare starts disarmed (all ones).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         irq_q      <= irq_d;
      end
   end

   // Register read mux, sampled by the responder when it enters ACK.
   always_comb begin
      case (rd_idx)
         TMR_MTIME_LO:    rd_data = mtime_q[31:0];
         TMR_MTIME_HI:    rd_data = mtime_q[63:32];
         TMR_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
         default:         rd_data = mtimecmp_q[63:32];
      endcase
   end

   assign irq = irq_q;

endmodule
`endif

// File: rtl/sentinel_wb_mem.sv
// sentinel_wb_mem: Wishbone classic responder serving word-addressed RAM
// with byte-lane writes and WAIT_STATES (0..2) wait cycles before ack.
// Optional machine timer enabled by defining SENTINEL_WB_MEM_TIMER_EN;
// without it the timer addresses are unmapped and irq is tied low.
module sentinel_wb_mem
   import sentinel_wb_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] bus__adr,
   input  logic        bus__cyc,
   input  logic        bus__stb,
   input  logic        bus__we,
   input  logic [3:0]  bus__sel,
   input  logic [31:0] bus__dat_w,
   output logic [31:0] bus__dat_r,
   output logic        bus__ack,
   output logic        irq
);

   // The IDLE cycle that accepts a request already counts toward latency,
   // so WAIT holds for WAIT_STATES cycles and is skipped when zero.
   localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

   wb_state_e   state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        ack_q, ack_d;
   logic [31:0] dat_r_q, dat_r_d;

   logic [29:0] adr_q, adr_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] dat_w_q, dat_w_d;

   logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

   logic [29:0] rd_adr;
   logic        rd_ram_hit, rd_tmr_hit;
   logic        wr_ram_hit, wr_tmr_hit;
   logic        wr_commit;
   logic [31:0] rd_data;
   logic [31:0] tmr_rdata;
   logic        tmr_irq;

   // Address for the read that lands in ACK: the bus address when skipping
   // WAIT straight out of IDLE, otherwise the latched one.
   assign rd_adr     = (state_q == ST_IDLE) ? bus__adr : adr_q;
   assign rd_ram_hit = (rd_adr[29:DEPTH_LOG2] == '0);
   assign wr_ram_hit = (adr_q[29:DEPTH_LOG2] == '0);
   assign wr_commit  = (state_q == ST_ACK) && we_q;

`ifdef SENTINEL_WB_MEM_TIMER_EN
   assign rd_tmr_hit = is_timer_adr(rd_adr);
   assign wr_tmr_hit = is_timer_adr(adr_q);

   sentinel_wb_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_commit && wr_tmr_hit),
      .wr_idx  (adr_q[1:0]),
      .wr_sel  (sel_q),
      .wr_data (dat_w_q),
      .rd_idx  (rd_adr[1:0]),
      .rd_data (tmr_rdata),
      .irq     (tmr_irq)
   );
`else
   assign rd_tmr_hit = 1'b0;
   assign wr_tmr_hit = 1'b0;
   assign tmr_rdata  = '0;
   assign tmr_irq    = 1'b0;
`endif

   // Read data source; unmapped addresses read as zero.
   always_comb begin
      rd_data = '0;
      if (rd_ram_hit) begin
         rd_data = mem[rd_adr[DEPTH_LOG2-1:0]];
      end else if (rd_tmr_hit) begin
         rd_data = tmr_rdata;
      end
   end

   // Handshake FSM next-state; ack and read data are set on entry to ACK.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      dat_r_d = '0;
      adr_d   = adr_q;
      we_d    = we_q;
      sel_d   = sel_q;
      dat_w_d = dat_w_q;
      case (state_q)
         ST_IDLE: begin
            if (bus__cyc && bus__stb) begin
               adr_d   = bus__adr;
               we_d    = bus__we;
               sel_d   = bus__sel;
               dat_w_d = bus__dat_w;
               cnt_d   = WAIT_LOAD;
               if (WAIT_STATES == 0) begin
                  state_d = ST_ACK;
                  ack_d   = 1'b1;
                  dat_r_d = rd_data;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!(bus__cyc && bus__stb)) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 2'd0) begin
               state_d = ST_ACK;
               ack_d   = 1'b1;
               dat_r_d = rd_data;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM and registered bus outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         ack_q   <= 1'b0;
         dat_r_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         dat_r_q <= dat_r_d;
      end
   end

   // Latched request fields; pure data, so no reset.
   always_ff @(posedge clk) begin
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_w_q <= dat_w_d;
   end

   // RAM write on the edge that ends ACK, per byte lane.
   always_ff @(posedge clk) begin
      if (wr_commit && wr_ram_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_q[b]) begin
               mem[adr_q[DEPTH_LOG2-1:0]][8*b +: 8] <= dat_w_q[8*b +: 8];
            end
         end
      end
   end

   assign bus__ack   = ack_q;
   assign bus__dat_r = dat_r_q;
   assign irq        = tmr_irq;

endmodule

// File: tb/tb_sentinel_wb_mem.sv
// tb_sentinel_wb_mem: directed self-checking bench for sentinel_wb_mem
// (default parameters, WAIT_STATES=1).
module tb_sentinel_wb_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] adr;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;
   logic        irq;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sentinel_wb_mem dut (
      .clk        (clk),
      .rst        (rst),
      .bus__adr   (adr),
      .bus__cyc   (cyc),
      .bus__stb   (stb),
      .bus__we    (we),
      .bus__sel   (sel),
      .bus__dat_w (dat_w),
      .bus__dat_r (dat_r),
      .bus__ack   (ack),
      .irq        (irq)
   );

   // One Wishbone transfer; n_cyc = cycles from request to ack (99 = no ack).
   task automatic bus_xfer(input logic [29:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd, output int n_cyc);
      @(posedge clk); #1;
      adr = a; we = w; sel = s; dat_w = d; cyc = 1'b1; stb = 1'b1;
      n_cyc = 99;
      rd = '0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) begin
            n_cyc = i;
            rd = dat_r;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
      checks++; if (dat_r !== 32'h0) begin errors++; $display("FAIL reset_dat_r: got %h expected 00000000", dat_r); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
   endtask

   task automatic test_basic_rw();
      logic [31:0] rd;
      int n;
      bus_xfer(30'h5, 1'b1, 4'hF, 32'hDEADBEEF, rd, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL basic_write_latency: got %0d expected 2", n); end
      bus_xfer(30'h5, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL basic_read_latency: got %0d expected 2", n); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_read_data: got %h expected deadbeef", rd); end
      @(posedge clk); #1;
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_single_pulse: got %b expected 0", ack); end
      checks++; if (dat_r !== 32'h0) begin errors++; $display("FAIL dat_r_zero_after_ack: got %h expected 00000000", dat_r); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd;
      int n;
      bus_xfer(30'h9, 1'b1, 4'hF, 32'h11223344, rd, n);
      bus_xfer(30'h9, 1'b1, 4'h1, 32'h000000AA, rd, n);
      bus_xfer(30'h9, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (rd !== 32'h112233AA) begin errors++; $display("FAIL lane_sel1: got %h expected 112233aa", rd); end
      bus_xfer(30'h9, 1'b1, 4'hC, 32'hBEEF0000, rd, n);
      bus_xfer(30'h9, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (rd !== 32'hBEEF33AA) begin errors++; $display("FAIL lane_selC: got %h expected beef33aa", rd); end
      bus_xfer(30'h9, 1'b1, 4'h0, 32'hFFFFFFFF, rd, n);
      bus_xfer(30'h9, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (rd !== 32'hBEEF33AA) begin errors++; $display("FAIL lane_sel0: got %h expected beef33aa", rd); end
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      int n;
      logic seen;
      seen = 1'b0;
      @(posedge clk); #1;
      adr = 30'h9; we = 1'b1; sel = 4'hF; dat_w = 32'h0; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      stb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (ack === 1'b1) seen = 1'b1;
      end
      cyc = 1'b0; we = 1'b0;
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ack: got %b expected 0", seen); end
      bus_xfer(30'h9, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (rd !== 32'hBEEF33AA) begin errors++; $display("FAIL abort_no_write: got %h expected beef33aa", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int n;
      @(posedge clk); #1;
      adr = 30'h9; we = 1'b1; sel = 4'hF; dat_w = 32'h55555555; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack_now: got %b expected 0", ack); end
      @(posedge clk); #1;
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack_held: got %b expected 0", ack); end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      rst = 1'b0;
      bus_xfer(30'h9, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL rst_mid_idle: got latency %0d expected 2", n); end
      checks++; if (rd !== 32'hBEEF33AA) begin errors++; $display("FAIL rst_mid_no_write: got %h expected beef33aa", rd); end
   endtask

   task automatic test_unmapped();
      logic [31:0] rd;
      int n;
      bus_xfer(30'h0, 1'b1, 4'hF, 32'hCAFEF00D, rd, n);
      bus_xfer(30'h0800_0000, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL unmapped_read_ack: got latency %0d expected 2", n); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read_data: got %h expected 00000000", rd); end
      bus_xfer(30'h0800_0000, 1'b1, 4'hF, 32'h12345678, rd, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL unmapped_write_ack: got latency %0d expected 2", n); end
      bus_xfer(30'h0, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL unmapped_no_alias: got %h expected cafef00d", rd); end
      bus_xfer(30'h0800_0000, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_write_ignored: got %h expected 00000000", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      int n;
      bus_xfer(30'h3, 1'b1, 4'hF, 32'h0BADF00D, rd, n);
      bus_xfer(30'h3, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_read_new: got %h expected 0badf00d", rd); end
      checks++; if (n !== 2) begin errors++; $display("FAIL b2b_latency: got %0d expected 2", n); end
      bus_xfer(30'h3FF, 1'b1, 4'hF, 32'hA5A5_0001, rd, n);
      bus_xfer(30'h3FE, 1'b1, 4'hF, 32'hA5A5_0002, rd, n);
      bus_xfer(30'h3FF, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (rd !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_top_word: got %h expected a5a50001", rd); end
      bus_xfer(30'h3FE, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (rd !== 32'hA5A5_0002) begin errors++; $display("FAIL b2b_next_word: got %h expected a5a50002", rd); end
   endtask

`ifdef SENTINEL_WB_MEM_TIMER_EN
   task automatic test_timer();
      logic [31:0] rd;
      int n;
      do_reset();
      bus_xfer(30'h1000_0003, 1'b1, 4'hF, 32'h0, rd, n);
      bus_xfer(30'h1000_0002, 1'b1, 4'hF, 32'd20, rd, n);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL timer_irq_early: got %b expected 0", irq); end
      // mtime := 0 on the edge ending this ACK; irq follows 21 edges later.
      bus_xfer(30'h1000_0000, 1'b1, 4'hF, 32'h0, rd, n);
      repeat (21) @(posedge clk);
      #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL timer_irq_before: got %b expected 0", irq); end
      @(posedge clk); #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL timer_irq_rise: got %b expected 1", irq); end
      bus_xfer(30'h1000_0002, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (rd !== 32'd20) begin errors++; $display("FAIL timer_cmp_lo_read: got %h expected 00000014", rd); end
      bus_xfer(30'h1000_0003, 1'b1, 4'hF, 32'hFFFFFFFF, rd, n);
      @(posedge clk); #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL timer_irq_hold: got %b expected 1", irq); end
      @(posedge clk); #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL timer_irq_fall: got %b expected 0", irq); end
   endtask
`else
   task automatic test_timer();
      logic [31:0] rd;
      int n;
      logic seen;
      seen = 1'b0;
      bus_xfer(30'h1000_0002, 1'b1, 4'hF, 32'h0, rd, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL notimer_write_ack: got latency %0d expected 2", n); end
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (irq !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL notimer_irq: got %b expected 0", seen); end
      bus_xfer(30'h1000_0003, 1'b0, 4'hF, 32'h0, rd, n);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL notimer_read: got %h expected 00000000", rd); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_rw();
      test_byte_lanes();
      test_abort();
      test_reset_mid();
      test_unmapped();
      test_back_to_back();
      test_timer();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
